// File: rtl/adc_interleave_sched.sv
// Round-robin scheduler that steers a registered 4:1 ADC mux and hands one
// frame of FRAME_LEN samples to a ready/valid downstream.
//
// state | meaning
// IDLE  | waiting for start with a non-empty channel mask
// ARB   | round-robin search among enabled channels with a sample pending
// FILL  | one-cycle wait while the registered mux captures the granted sample
// HOLD  | mux output presented, waiting for ready_out
// DONE  | frame complete, frame_done pulse, back to IDLE
module adc_interleave_sched #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       ch_enable,
  input  logic [3:0]       sample_valid,
  input  logic             ready_out,
  output logic [1:0]       x_adc_select,
  output logic [3:0]       sel_ack,
  output logic             mux_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    FILL = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       last_grant;
  logic [3:0]       mask;
  logic [3:0]       candidates;
  logic [1:0]       probe;
  logic [1:0]       winner;
  logic             found;
  logic [CNT_W-1:0] count_next;

  assign candidates = mask & sample_valid;
  assign count_next = sample_count + CNT_W'(1);

  // Search starts one past the previous grant; the 2-bit add wraps 3 -> 0 and
  // the last probe lands back on last_grant itself.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    probe  = last_grant;
    for (int i = 1; i <= 4; i++) begin
      probe = last_grant + 2'(i);
      if (!found && candidates[probe]) begin
        found  = 1'b1;
        winner = probe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      state        <= IDLE;
      x_adc_select <= 2'd0;
      sel_ack      <= 4'b0000;
      mux_valid    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      sample_count <= '0;
      last_grant   <= 2'd3;
      mask         <= 4'b0000;
    end else begin
      sel_ack    <= 4'b0000;
      frame_done <= 1'b0;
      if (abort && state != IDLE) begin
        // abort beats a simultaneous handshake: the sample is dropped uncounted
        state     <= IDLE;
        mux_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && ch_enable != 4'b0000) begin
              mask         <= ch_enable;
              sample_count <= '0;
              busy         <= 1'b1;
              state        <= ARB;
            end
          end
          ARB: begin
            if (found) begin
              x_adc_select <= winner;
              sel_ack      <= 4'b0001 << winner;
              last_grant   <= winner;
              state        <= FILL;
            end
          end
          FILL: begin
            mux_valid <= 1'b1;
            state     <= HOLD;
          end
          HOLD: begin
            if (ready_out) begin
              sample_count <= count_next;
              mux_valid    <= 1'b0;
              if (count_next == CNT_W'(FRAME_LEN)) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= DONE;
              end else begin
                state <= ARB;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state     <= IDLE;
            mux_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_interleave_sched.sv
// Scoreboard bench for adc_interleave_sched: the stimulus side plans expected
// grants from a round-robin model, a negedge monitor pops and compares them.
module tb_adc_interleave_sched;
  localparam int FL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          GlobalReset;
  logic          start;
  logic          abort;
  logic [3:0]    ch_enable;
  logic [3:0]    sample_valid;
  logic          ready_out;
  logic [1:0]    x_adc_select;
  logic [3:0]    sel_ack;
  logic          mux_valid;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] sample_count;

  typedef struct {
    logic [1:0] ch;
    int         cnt;
  } grant_t;

  grant_t gq[$];
  int     dq[$];
  int     model_last = 3;
  int     ack_cnt[4] = '{0, 0, 0, 0};
  int     checks = 0;
  int     errors = 0;

  adc_interleave_sched #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .start        (start),
    .abort        (abort),
    .ch_enable    (ch_enable),
    .sample_valid (sample_valid),
    .ready_out    (ready_out),
    .x_adc_select (x_adc_select),
    .sel_ack      (sel_ack),
    .mux_valid    (mux_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Next channel after `last` that holds a candidate, wrapping modulo 4.
  function automatic int rr_next(input logic [3:0] cand, input int last);
    for (int k = 1; k <= 4; k++)
      if (cand[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  task automatic plan(input logic [3:0] cand, input int first, input int n, input bit done);
    for (int i = first; i < first + n; i++) begin
      model_last = rr_next(cand, model_last);
      gq.push_back('{2'(model_last), i});
    end
    if (done) dq.push_back(FL);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 2000) begin
      step();
      cyc++;
    end
    chk("frame_done_seen", frame_done, 1);
  endtask

  task automatic wait_hold(input int cnt);
    int n = 0;
    while (!(mux_valid === 1'b1 && sample_count == CW'(cnt)) && n < 200) begin
      step();
      n++;
    end
    chk("hold_reached", mux_valid, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_select", x_adc_select, 0);
    chk("rst_ack", sel_ack, 0);
    chk("rst_mux_valid", mux_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_count", sample_count, 0);
  endtask

  initial begin
    grant_t g;
    int     e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (sel_ack[k] === 1'b1) ack_cnt[k]++;
      if (sel_ack !== 4'b0000) begin
        if (gq.size() == 0) begin
          chk("unexpected_ack", sel_ack, 0);
        end else begin
          g = gq.pop_front();
          chk("grant_sel", x_adc_select, g.ch);
          chk("grant_ack", sel_ack, 4'b0001 << g.ch);
          chk("grant_count", sample_count, g.cnt);
        end
      end
      if (frame_done !== 1'b0) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", frame_done, 0);
        end else begin
          e = dq.pop_front();
          chk("done_count", sample_count, e);
        end
      end
    end
  end

  initial begin
    int cyc;
    int s1, s3;
    logic [3:0] m, c;
    logic [1:0] held_sel;

    GlobalReset  = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    ch_enable    = 4'b0000;
    sample_valid = 4'b0000;
    ready_out    = 1'b0;
    step(2);
    check_reset_outputs();
    GlobalReset = 1'b1;
    step();

    // start with an empty mask is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_mask_busy", busy, 0);

    // full mask, always valid, always ready: 3 cycles per sample
    ch_enable = 4'b1111; sample_valid = 4'b1111; ready_out = 1'b1;
    plan(4'b1111, 0, FL, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    wait_done(cyc);
    chk("done_latency", cyc, 12);
    chk("busy_in_done", busy, 0);
    step();
    chk("done_one_cycle", frame_done, 0);
    chk("final_count_held", sample_count, FL);

    // alternate-channel mask
    s1 = ack_cnt[1]; s3 = ack_cnt[3];
    ch_enable = 4'b0101;
    plan(4'b0101, 0, FL, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    ch_enable = 4'b1111;
    wait_done(cyc);
    chk("ch1_never_acked", ack_cnt[1] - s1, 0);
    chk("ch3_never_acked", ack_cnt[3] - s3, 0);
    step();

    // back-pressure in HOLD
    ready_out = 1'b0; ch_enable = 4'b1111;
    plan(4'b1111, 0, FL, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_hold(0);
    held_sel = 2'(gq.size() == FL ? 0 : (model_last + 1) % 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_select_stable", x_adc_select, held_sel);
      chk("hold_valid_stable", mux_valid, 1);
      chk("hold_count_stable", sample_count, 0);
    end
    ready_out = 1'b1;
    wait_done(cyc);
    step();

    // no candidates for a while, then only channel 2
    sample_valid = 4'b0000;
    held_sel = 2'(model_last);
    plan(4'b0100, 0, 1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_no_ack", sel_ack, 0);
      chk("stall_select_hold", x_adc_select, held_sel);
      step();
    end
    sample_valid = 4'b0100;
    step();
    chk("stall_release_ack", sel_ack, 4'b0100);
    chk("stall_release_sel", x_adc_select, 2);
    sample_valid = 4'b1111;
    plan(4'b1111, 1, FL - 1, 1);
    wait_done(cyc);
    step();

    // abort coinciding with a handshake on the third sample
    plan(4'b1111, 0, 3, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_hold(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_mux_valid", mux_valid, 0);
    chk("abort_count", sample_count, 2);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", frame_done, 0);
      step();
    end
    chk("abort_count_held", sample_count, 2);
    plan(4'b1111, 0, FL, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_clears_count", sample_count, 0);
    wait_done(cyc);
    step();

    // reset in the middle of HOLD
    ready_out = 1'b0;
    plan(4'b1111, 0, 1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_hold(0);
    GlobalReset = 1'b0;
    ready_out = 1'b1;
    abort = 1'b1;
    step();
    GlobalReset = 1'b1;
    abort = 1'b0;
    check_reset_outputs();
    model_last = 3;
    plan(4'b1111, 0, FL, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc);
    step();

    // randomized frames: constant candidate set per frame, noisy other inputs
    for (int f = 0; f < 25; f++) begin
      m = 4'($urandom_range(1, 15));
      c = m & 4'($urandom_range(1, 15));
      if (c == 4'b0000) c = m;
      ch_enable    = m;
      sample_valid = c | (4'($urandom) & ~m);
      ready_out    = 1'($urandom);
      plan(c, 0, FL, 1);
      start = 1'b1;
      step();
      cyc = 0;
      while (frame_done !== 1'b1 && cyc < 500) begin
        start        = 1'($urandom);
        ch_enable    = 4'($urandom);
        sample_valid = c | (4'($urandom) & ~m);
        ready_out    = 1'($urandom);
        step();
        cyc++;
      end
      start = 1'b0;
      chk("rand_frame_done", frame_done, 1);
      step();
    end

    step(3);
    chk("grants_drained", gq.size(), 0);
    chk("dones_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
